sprite_plotter: RTL and testbench

SPRITE_PLOTTER -- requirements
Module: sprite_plotter

---
 rtl/sprite_plotter_if.sv | 31 +++
 rtl/sprite_plotter.sv | 142 ++++++++++++++
 tb/tb_sprite_plotter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_plotter_if.sv
// Move request in, single-pixel VGA write port and status out.
// The plotter side uses the slave modport; the requester uses master.
interface sprite_plotter_if;
    localparam int unsigned X_W = 8;
    localparam int unsigned Y_W = 7;
    localparam int unsigned C_W = 3;

    logic             start;
    logic [X_W-1:0]   old_x;
    logic [Y_W-1:0]   old_y;
    logic [X_W-1:0]   new_x;
    logic [Y_W-1:0]   new_y;
    logic [C_W-1:0]   colour;
    logic [C_W-1:0]   bg_colour;
    logic [X_W-1:0]   vga_x;
    logic [Y_W-1:0]   vga_y;
    logic [C_W-1:0]   vga_colour;
    logic             vga_plot;
    logic             busy;
    logic             done;

    modport master (
        output start, old_x, old_y, new_x, new_y, colour, bg_colour,
        input  vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport slave (
        input  start, old_x, old_y, new_x, new_y, colour, bg_colour,
        output vga_x, vga_y, vga_colour, vga_plot, busy, done
    );
endinterface

// File: rtl/sprite_plotter.sv
// Moves a BOX x BOX sprite: erases the old square with the background colour,
// redraws it at the new position, then pulses done. One pixel per cycle.
module sprite_plotter #(
    parameter int BOX   = 4,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    sprite_plotter_if.slave  bus
);
    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned C_W   = 3;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] BOX_C  = CNT_W'(BOX);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(BOX * BOX - 1);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [X_W-1:0]   ox_q, ox_nx, nx_q, nx_nx;
    logic [Y_W-1:0]   oy_q, oy_nx, ny_q, ny_nx;
    logic [C_W-1:0]   col_q, col_nx, bg_q, bg_nx;

    logic [X_W-1:0]   vga_x_q, vga_x_nx;
    logic [Y_W-1:0]   vga_y_q, vga_y_nx;
    logic [C_W-1:0]   vga_col_q, vga_col_nx;
    logic             plot_q, plot_nx, busy_q, busy_nx, done_q, done_nx;

    logic [CNT_W-1:0] dx, dy;
    logic [X_W:0]     sum_x;
    logic [Y_W:0]     sum_y;
    logic [X_W-1:0]   base_x;
    logic [Y_W-1:0]   base_y;

    // State, counter, latched request and registered pixel port
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            nx_q      <= '0;
            ny_q      <= '0;
            col_q     <= '0;
            bg_q      <= '0;
            vga_x_q   <= '0;
            vga_y_q   <= '0;
            vga_col_q <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ox_q      <= ox_nx;
            oy_q      <= oy_nx;
            nx_q      <= nx_nx;
            ny_q      <= ny_nx;
            col_q     <= col_nx;
            bg_q      <= bg_nx;
            vga_x_q   <= vga_x_nx;
            vga_y_q   <= vga_y_nx;
            vga_col_q <= vga_col_nx;
            plot_q    <= plot_nx;
            busy_q    <= busy_nx;
            done_q    <= done_nx;
        end
    end

    // Next state; outputs are derived from the state being entered so that
    // the registered pixel lines up with the cycle that owns it.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ox_nx      = ox_q;
        oy_nx      = oy_q;
        nx_nx      = nx_q;
        ny_nx      = ny_q;
        col_nx     = col_q;
        bg_nx      = bg_q;
        vga_x_nx   = vga_x_q;
        vga_y_nx   = vga_y_q;
        vga_col_nx = vga_col_q;
        plot_nx    = 1'b0;
        busy_nx    = 1'b0;
        done_nx    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    ox_nx    = bus.old_x;
                    oy_nx    = bus.old_y;
                    nx_nx    = bus.new_x;
                    ny_nx    = bus.new_y;
                    col_nx   = bus.colour;
                    bg_nx    = bus.bg_colour;
                    cnt_nx   = '0;
                    state_nx = ERASE;
                end
            end
            ERASE: begin
                if (cnt == LAST_C) begin
                    cnt_nx   = '0;
                    state_nx = DRAW;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DRAW: begin
                if (cnt == LAST_C) state_nx = DONE;
                else               cnt_nx   = cnt + CNT_W'(1);
            end
            default: state_nx = IDLE;
        endcase

        dx     = cnt_nx % BOX_C;
        dy     = cnt_nx / BOX_C;
        base_x = (state_nx == ERASE) ? ox_nx : nx_nx;
        base_y = (state_nx == ERASE) ? oy_nx : ny_nx;
        sum_x  = (X_W + 1)'(base_x) + (X_W + 1)'(dx);
        sum_y  = (Y_W + 1)'(base_y) + (Y_W + 1)'(dy);

        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
        if (state_nx == ERASE || state_nx == DRAW) begin
            vga_x_nx   = sum_x[X_W-1:0];
            vga_y_nx   = sum_y[Y_W-1:0];
            vga_col_nx = (state_nx == ERASE) ? bg_nx : col_nx;
            plot_nx    = (sum_x <= (X_W + 1)'(X_MAX)) && (sum_y <= (Y_W + 1)'(Y_MAX));
        end
    end

    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_col_q;
    assign bus.vga_plot   = plot_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: BOX=4 instance for moves, clipping,
// ignored restarts, mid-move reset and back-to-back; BOX=1 instance for the minimal move.
module tb_sprite_plotter;
    logic CLOCK_50 = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    sprite_plotter_if bif ();
    sprite_plotter_if bif1 ();

    sprite_plotter #(.BOX(4), .X_MAX(159), .Y_MAX(119)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bif.slave)
    );

    sprite_plotter #(.BOX(1), .X_MAX(159), .Y_MAX(119)) dut1 (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bif1.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_move(input int ox, input int oy, input int nx, input int ny,
                            input int col, input int bg);
        bif.old_x     = 8'(ox);
        bif.old_y     = 7'(oy);
        bif.new_x     = 8'(nx);
        bif.new_y     = 7'(ny);
        bif.colour    = 3'(col);
        bif.bg_colour = 3'(bg);
    endtask

    // Called in cycle 1 of a move; walks all 33 cycles plus the following IDLE cycle.
    task automatic check_move(input int ox, input int oy, input int nx, input int ny,
                              input int col, input int bg, input bit poke,
                              output int erase_plots, output int draw_plots);
        bit er;
        int k, ex, ey;
        bit ep;
        erase_plots = 0;
        draw_plots  = 0;
        for (int i = 0; i < 32; i++) begin
            er = (i < 16);
            k  = er ? i : i - 16;
            ex = (er ? ox : nx) + k % 4;
            ey = (er ? oy : ny) + k / 4;
            ep = (ex <= 159) && (ey <= 119);
            check("plot", 32'(bif.vga_plot), 32'(ep));
            check("x", 32'(bif.vga_x), 32'(ex & 255));
            check("y", 32'(bif.vga_y), 32'(ey & 127));
            check("colour", 32'(bif.vga_colour), 32'(er ? bg : col));
            check("busy", 32'(bif.busy), 32'd1);
            check("done_early", 32'(bif.done), 32'd0);
            if (bif.vga_plot) begin
                if (er) erase_plots++;
                else    draw_plots++;
            end
            if (poke && i == 4) begin
                bif.start = 1'b1;
                set_move(70, 80, 90, 100, 1, 6);
            end
            if (poke && i == 5) bif.start = 1'b0;
            tick;
        end
        check("done", 32'(bif.done), 32'd1);
        check("plot_done", 32'(bif.vga_plot), 32'd0);
        tick;
        check("done_clear", 32'(bif.done), 32'd0);
        check("busy_idle", 32'(bif.busy), 32'd0);
        check("plot_idle", 32'(bif.vga_plot), 32'd0);
    endtask

    int ep_n, dp_n;

    initial begin
        reset      = 1'b1;
        bif.start  = 1'b0;
        bif1.start = 1'b0;
        set_move(0, 0, 0, 0, 0, 0);
        bif1.old_x = '0; bif1.old_y = '0; bif1.new_x = '0; bif1.new_y = '0;
        bif1.colour = '0; bif1.bg_colour = '0;
        tick;
        tick;
        check("rst_x", 32'(bif.vga_x), 32'd0);
        check("rst_y", 32'(bif.vga_y), 32'd0);
        check("rst_colour", 32'(bif.vga_colour), 32'd0);
        check("rst_plot", 32'(bif.vga_plot), 32'd0);
        check("rst_busy", 32'(bif.busy), 32'd0);
        check("rst_done", 32'(bif.done), 32'd0);
        check("rst1_plot", 32'(bif1.vga_plot), 32'd0);
        reset = 1'b0;
        tick;
        check("idle_busy", 32'(bif.busy), 32'd0);

        // Basic move, then IDLE holds the last pixel
        set_move(10, 20, 11, 20, 4, 0);
        bif.start = 1'b1;
        tick;
        bif.start = 1'b0;
        check_move(10, 20, 11, 20, 4, 0, 1'b0, ep_n, dp_n);
        check("basic_erase_plots", 32'(ep_n), 32'd16);
        check("basic_draw_plots", 32'(dp_n), 32'd16);
        check("hold_x", 32'(bif.vga_x), 32'd14);
        check("hold_y", 32'(bif.vga_y), 32'd23);
        check("hold_colour", 32'(bif.vga_colour), 32'd4);

        // Clipping at the bottom-right corner
        set_move(10, 20, 158, 118, 2, 1);
        bif.start = 1'b1;
        tick;
        bif.start = 1'b0;
        check_move(10, 20, 158, 118, 2, 1, 1'b0, ep_n, dp_n);
        check("clip_draw_plots", 32'(dp_n), 32'd4);

        // Restart attempt mid-move is ignored
        set_move(30, 40, 31, 41, 7, 5);
        bif.start = 1'b1;
        tick;
        bif.start = 1'b0;
        check_move(30, 40, 31, 41, 7, 5, 1'b1, ep_n, dp_n);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("no_second_done", 32'(bif.done), 32'd0);
            check("no_second_busy", 32'(bif.busy), 32'd0);
        end

        // Same old and new position still erases and redraws
        set_move(60, 60, 60, 60, 6, 0);
        bif.start = 1'b1;
        tick;
        bif.start = 1'b0;
        check_move(60, 60, 60, 60, 6, 0, 1'b0, ep_n, dp_n);
        check("same_erase_plots", 32'(ep_n), 32'd16);

        // Reset during DRAW cycle 3, with start asserted alongside it
        set_move(5, 5, 6, 6, 3, 2);
        bif.start = 1'b1;
        tick;
        bif.start = 1'b0;
        for (int i = 0; i < 18; i++) tick;
        check("mid_draw_colour", 32'(bif.vga_colour), 32'd3);
        check("mid_draw_x", 32'(bif.vga_x), 32'd8);
        reset     = 1'b1;
        bif.start = 1'b1;
        tick;
        check("mrst_x", 32'(bif.vga_x), 32'd0);
        check("mrst_y", 32'(bif.vga_y), 32'd0);
        check("mrst_colour", 32'(bif.vga_colour), 32'd0);
        check("mrst_plot", 32'(bif.vga_plot), 32'd0);
        check("mrst_busy", 32'(bif.busy), 32'd0);
        check("mrst_done", 32'(bif.done), 32'd0);
        reset     = 1'b0;
        bif.start = 1'b0;
        tick;
        check("post_rst_busy", 32'(bif.busy), 32'd0);
        check("post_rst_plot", 32'(bif.vga_plot), 32'd0);
        set_move(20, 30, 24, 34, 5, 1);
        bif.start = 1'b1;
        tick;
        bif.start = 1'b0;
        check_move(20, 30, 24, 34, 5, 1, 1'b0, ep_n, dp_n);

        // Back-to-back: start held through the IDLE cycle between moves
        set_move(100, 50, 101, 51, 7, 0);
        bif.start = 1'b1;
        tick;
        check_move(100, 50, 101, 51, 7, 0, 1'b0, ep_n, dp_n);
        tick;
        bif.start = 1'b0;
        check("b2b_restart_busy", 32'(bif.busy), 32'd1);
        check_move(100, 50, 101, 51, 7, 0, 1'b0, ep_n, dp_n);

        // BOX=1: one erase plot, one draw plot, done in cycle 3
        bif1.old_x = 8'd3;  bif1.old_y = 7'd4;
        bif1.new_x = 8'd5;  bif1.new_y = 7'd6;
        bif1.colour = 3'd3; bif1.bg_colour = 3'd1;
        bif1.start = 1'b1;
        tick;
        bif1.start = 1'b0;
        check("b1_e_plot", 32'(bif1.vga_plot), 32'd1);
        check("b1_e_x", 32'(bif1.vga_x), 32'd3);
        check("b1_e_y", 32'(bif1.vga_y), 32'd4);
        check("b1_e_colour", 32'(bif1.vga_colour), 32'd1);
        check("b1_busy", 32'(bif1.busy), 32'd1);
        tick;
        check("b1_d_plot", 32'(bif1.vga_plot), 32'd1);
        check("b1_d_x", 32'(bif1.vga_x), 32'd5);
        check("b1_d_y", 32'(bif1.vga_y), 32'd6);
        check("b1_d_colour", 32'(bif1.vga_colour), 32'd3);
        tick;
        check("b1_done", 32'(bif1.done), 32'd1);
        check("b1_done_plot", 32'(bif1.vga_plot), 32'd0);
        tick;
        check("b1_done_clear", 32'(bif1.done), 32'd0);
        check("b1_busy_idle", 32'(bif1.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
